// File: rtl/dsm_cic_decoder.sv
// Third-order CIC (sinc^3) decimator turning the 1-bit delta-sigma stream back into
// signed PCM; decimation ratio 2**osr, one output strobe per decimated frame.
module dsm_cic_decoder #(
  parameter int dac_bw = 16,
  parameter int osr    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din,
  output logic signed [dac_bw-1:0] dout,
  output logic                     dout_valid
);

  localparam int W     = 3 * osr + 2;
  localparam int SHIFT = 3 * osr - (dac_bw - 1);
  localparam logic signed [W-1:0] POS_LIM = W'((2 ** (dac_bw - 1)) - 1);
  localparam logic signed [W-1:0] NEG_LIM = ~POS_LIM;

  logic                    dinR_q;
  logic signed [W-1:0]     sampleVal;
  logic signed [W-1:0]     integ1_q, integ1_d, integ2_q, integ2_d, integ3_q, integ3_d;
  logic [osr-1:0]          decCnt_q, decCnt_d;
  logic                    frameEnd;
  logic [7:0]              tick_q, tick_d;
  logic signed [W-1:0]     capture_q, capture_d;
  logic signed [W-1:0]     comb1_q, comb1_d, comb2_q, comb2_d, comb3_q, comb3_d;
  logic signed [W-1:0]     dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  logic signed [W-1:0]     shifted;
  logic signed [dac_bw-1:0] satVal;
  logic signed [dac_bw-1:0] dout_d;
  logic                    doutValid_d;
  logic [1:0]              settle_q, settle_d;

  // Bit 0 is +1 and bit 1 is -1, matching the modulator's sign output.
  assign sampleVal = dinR_q ? {W{1'b1}} : {{(W-1){1'b0}}, 1'b1};
  assign frameEnd  = (decCnt_q == {osr{1'b1}});

  always_comb begin
    shifted = comb3_q >>> SHIFT;
    satVal  = shifted[dac_bw-1:0];
    if (shifted > POS_LIM) begin
      satVal = POS_LIM[dac_bw-1:0];
    end else if (shifted < NEG_LIM) begin
      satVal = NEG_LIM[dac_bw-1:0];
    end
  end

  // The tick trails the frame boundary by the integrator depth (tick_q[3]) so each
  // capture holds exactly one frame's worth of bits; later taps step the combs.
  always_comb begin
    integ1_d    = integ1_q + sampleVal;
    integ2_d    = integ2_q + integ1_q;
    integ3_d    = integ3_q + integ2_q;
    decCnt_d    = decCnt_q + {{(osr-1){1'b0}}, 1'b1};
    tick_d      = {tick_q[6:0], frameEnd};
    capture_d   = capture_q;
    comb1_d     = comb1_q;
    comb2_d     = comb2_q;
    comb3_d     = comb3_q;
    dly1_d      = dly1_q;
    dly2_d      = dly2_q;
    dly3_d      = dly3_q;
    dout_d      = dout;
    doutValid_d = 1'b0;
    settle_d    = settle_q;
    if (tick_q[3]) begin
      capture_d = integ3_q;
    end
    if (tick_q[4]) begin
      comb1_d = capture_q - dly1_q;
      dly1_d  = capture_q;
    end
    if (tick_q[5]) begin
      comb2_d = comb1_q - dly2_q;
      dly2_d  = comb1_q;
    end
    if (tick_q[6]) begin
      comb3_d = comb2_q - dly3_q;
      dly3_d  = comb2_q;
    end
    // The first three samples carry filter start-up transients and are not flagged.
    if (tick_q[7]) begin
      dout_d      = satVal;
      doutValid_d = (settle_q == 2'd3);
      if (settle_q != 2'd3) begin
        settle_d = settle_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dinR_q     <= 1'b0;
      integ1_q   <= '0;
      integ2_q   <= '0;
      integ3_q   <= '0;
      decCnt_q   <= '0;
      tick_q     <= '0;
      capture_q  <= '0;
      comb1_q    <= '0;
      comb2_q    <= '0;
      comb3_q    <= '0;
      dly1_q     <= '0;
      dly2_q     <= '0;
      dly3_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      settle_q   <= '0;
    end else begin
      dinR_q     <= din;
      integ1_q   <= integ1_d;
      integ2_q   <= integ2_d;
      integ3_q   <= integ3_d;
      decCnt_q   <= decCnt_d;
      tick_q     <= tick_d;
      capture_q  <= capture_d;
      comb1_q    <= comb1_d;
      comb2_q    <= comb2_d;
      comb3_q    <= comb3_d;
      dly1_q     <= dly1_d;
      dly2_q     <= dly2_d;
      dly3_q     <= dly3_d;
      dout       <= dout_d;
      dout_valid <= doutValid_d;
      settle_q   <= settle_d;
    end
  end

endmodule

// File: tb/tb_dsm_cic_decoder.sv
// Scoreboarded bench for dsm_cic_decoder: periodic bitstreams with known mean,
// expected strobes queued per frame and checked when the DUT strobes.
module tb_dsm_cic_decoder;

  localparam int R          = 64;
  localparam int LATENCY    = 8;
  localparam int FIRSTFRAME = 3;

  typedef struct {
    int edgeAt;
    int value;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               din = 1'b0;
  logic signed [15:0] dout;
  logic               dout_valid;

  int   tests = 0;
  int   failures = 0;
  exp_t expQ[$];
  logic prevValid = 1'b0;

  dsm_cic_decoder #(.dac_bw(16), .osr(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // Holds reset for two edges and releases it so the next rising edge is edge 1.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (2) @(negedge clk);
    expQ.delete();
    prevValid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Drives a periodic pattern (bit 0 first) for nClks edges, queueing the expected
  // strobe for every settled frame and checking each strobe as it appears.
  task automatic applyStimulus(input logic [15:0] pat, input int len, input int nClks,
                               input int expVal, input int zeroUntil);
    exp_t cur;
    logic signed [15:0] expDout;
    for (int n = 1; n <= nClks; n++) begin
      din = pat[(n - 1) % len];
      if ((n % R == 0) && (n / R - 1 >= FIRSTFRAME) && (n + LATENCY <= nClks)) begin
        cur.edgeAt = n + LATENCY;
        cur.value  = expVal;
        expQ.push_back(cur);
      end
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        tests++;
        if (prevValid) begin
          failures++;
          $display("[TB] FAIL strobe_spacing at edge %0d: got consecutive strobes, required gap", n);
        end
        tests++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_strobe at edge %0d: got strobe, required none", n);
        end else begin
          cur = expQ.pop_front();
          expDout = 16'(cur.value);
          if (n !== cur.edgeAt) begin
            failures++;
            $display("[TB] FAIL strobe_edge: got edge %0d, required edge %0d", n, cur.edgeAt);
          end
          tests++;
          if (dout !== expDout) begin
            failures++;
            $display("[TB] FAIL strobe_value at edge %0d: got %0d, required %0d", n, dout, expDout);
          end
        end
      end else if (n < zeroUntil) begin
        tests++;
        if (dout !== 16'sd0) begin
          failures++;
          $display("[TB] FAIL dout_after_reset at edge %0d: got %0d, required 0", n, dout);
        end
      end
      prevValid = (dout_valid === 1'b1);
    end
    #1;
    tests++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL missing_strobe: got %0d strobes outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (dout !== 16'sd0) begin
      failures++;
      $display("[TB] FAIL reset_dout: got %0d, required 0", dout);
    end
    tests++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b, required 0", dout_valid);
    end
  endtask

  task automatic test_zeros();
    doReset();
    applyStimulus(16'b0, 1, 2000, 32767, 0);
  endtask

  task automatic test_ones();
    doReset();
    applyStimulus(16'b1, 1, 2000, -32768, 0);
  endtask

  task automatic test_alternating();
    doReset();
    applyStimulus(16'b10, 2, 2000, 0, 0);
  endtask

  task automatic test_quarter();
    doReset();
    applyStimulus(16'b1000, 4, 2000, 16384, 0);
    doReset();
    applyStimulus(16'b0111, 4, 2000, -16384, 0);
  endtask

  task automatic test_long_run();
    doReset();
    applyStimulus(16'b0, 1, 20000, 32767, 0);
  endtask

  // A one-clock reset five edges before the strobe due at edge 328 must kill it.
  task automatic test_reset_mid();
    doReset();
    applyStimulus(16'b0, 1, 322, 32767, 0);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (dout !== 16'sd0) begin
      failures++;
      $display("[TB] FAIL midreset_dout: got %0d, required 0", dout);
    end
    tests++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_valid: got %b, required 0", dout_valid);
    end
    rst_n = 1'b1;
    prevValid = 1'b0;
    applyStimulus(16'b0, 1, 340, 32767, 72);
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_alternating();
    test_quarter();
    test_long_run();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
